// File: rtl/load_store_unit32_if.sv
// Core-side request/response bundle of load_store_unit32.
// The master modport is the execute stage; the slave modport is the LSU.
interface load_store_unit32_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit32.sv
// RV32I load/store unit over word-only data_memory32; sub-word stores by read-modify-write. Load/SW 2, SB/SH 3, error 1 cycle after accept.
// One request in flight (req_ready only in IDLE), response pulse has no backpressure; LSU_BOUNDS_CHECK_EN adds out-of-range errors.
module load_store_unit32 #(
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit32_if.slave  lsu,
  output logic                o_mem_we,
  output logic [31:0]         o_mem_addr,
  output logic [31:0]         o_mem_wdata,
  input  logic [31:0]         i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_idx;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_bad_f3;
  logic        w_misalign;
  logic        w_oob;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_accept = lsu.req_valid && (r_state == S_IDLE);

  always_comb begin
    w_bad_f3 = 1'b0;
    if (lsu.req_we)
      w_bad_f3 = !(lsu.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      w_bad_f3 = !(lsu.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  assign w_misalign = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                      ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob = ({2'b00, lsu.req_addr[31:2]} >= 32'(DEPTH));
`else
  assign w_oob = 1'b0;
`endif

  assign w_err = w_bad_f3 || w_misalign || w_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)
            w_state_nxt = S_RESP;
          else if (lsu.req_we && (lsu.req_funct3[1:0] == 2'b10))
            w_state_nxt = S_WR;
          else
            w_state_nxt = S_RD;
        end
      end
      S_RD:    w_state_nxt = r_we ? S_WR : S_RESP;
      S_WR:    w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = i_mem_rdata;
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = 32'h0;
    endcase
  end

  // Store data merged into the word captured in RD; SW ignores the capture.
  always_comb begin
    w_merge = r_word;
    case (r_f3[1:0])
      2'b00:   w_merge[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      2'b01:   w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_lane  <= 2'b00;
      r_idx   <= 32'h0;
      r_wdata <= 32'h0;
      r_word  <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= lsu.req_we;
        r_f3    <= lsu.req_funct3;
        r_lane  <= lsu.req_addr[1:0];
        r_idx   <= {2'b00, lsu.req_addr[31:2]} % 32'(DEPTH);
        r_wdata <= lsu.req_wdata;
        r_rdata <= 32'h0;
        r_err   <= w_err;
      end
      if (r_state == S_RD) begin
        r_word <= i_mem_rdata;
        if (!r_we) r_rdata <= w_ext;
      end
    end
  end

  // Decoded from the state flop so an asynchronous reset drops the write strobe at once.
  assign o_mem_we       = (r_state == S_WR);
  assign o_mem_addr     = r_idx;
  assign o_mem_wdata    = w_merge;
  assign lsu.req_ready  = (r_state == S_IDLE);
  assign lsu.resp_valid = (r_state == S_RESP);
  assign lsu.resp_rdata = r_rdata;
  assign lsu.resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit32.sv
// Self-checking bench for load_store_unit32 with a word-only memory model and an arithmetic reference model.
module tb_load_store_unit32;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  bit [31:0] mem     [DEPTH];
  bit [31:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  load_store_unit32_if bus();

  load_store_unit32 #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu         (bus),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:0]];

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit        err;
    int        lat;
    int        wes;
    bit [31:0] word4;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed semantics computed with plain arithmetic on ref_mem.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                       output bit [31:0] rd, output bit err, output int lat, output int wes);
    longint unsigned w, v, mask;
    int sz, off, idx;
    off = int'(a % 4);
    idx = int'(a >> 2);
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      default:    sz = 4;
    endcase
    if (we) err = (f3 > 3'd2);
    else    err = (f3 == 3'd3) || (f3 > 3'd5);
    if (off % sz != 0) err = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if (idx >= DEPTH) err = 1'b1;
`endif
    rd  = 32'h0;
    wes = 0;
    if (err) begin
      lat = 1;
      return;
    end
    idx  = idx % DEPTH;
    w    = longint'(ref_mem[idx]);
    mask = (64'd1 << (8 * sz)) - 1;
    if (!we) begin
      v = (w >> (8 * off)) & mask;
      if (f3 < 3'd4 && sz < 4 && v >= (mask + 1) / 2) v = v + (64'hFFFF_FFFF - mask);
      rd  = v[31:0];
      lat = 2;
    end else begin
      v = (w & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
      ref_mem[idx] = v[31:0];
      lat = (sz == 4) ? 2 : 3;
      wes = 1;
    end
  endtask

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat, output int wes);
    rd  = 32'h0;
    err = 1'b0;
    lat = -1;
    wes = 0;
    @(negedge clk);
    chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) wes++;
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, wes, nresp, idx;
    bit [31:0]   m_rd, a, wd;
    bit          m_err, we;
    bit [2:0]    f3;
    int          m_lat, m_wes;

    tv[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    tv[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'hDEADBEEF};
    tv[3]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2, 0, 32'hDEADBEEF};
    tv[4]  = '{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'hDEADBEEF};
    tv[5]  = '{1'b0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    tv[6]  = '{1'b1, 3'd0, 32'h11, 32'h12345655, 32'h0,        1'b0, 3, 1, 32'hDEAD55EF};
    tv[7]  = '{1'b1, 3'd1, 32'h12, 32'h0000CAFE, 32'h0,        1'b0, 3, 1, 32'hCAFE55EF};
    tv[8]  = '{1'b0, 3'd2, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 32'hCAFE55EF};
    tv[9]  = '{1'b1, 3'd1, 32'h13, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'hCAFE55EF};
    tv[10] = '{1'b0, 3'd0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 32'hCAFE55EF};
    tv[11] = '{1'b0, 3'd1, 32'h10, 32'h0,        32'h000055EF, 1'b0, 2, 0, 32'hCAFE55EF};
    tv[12] = '{1'b0, 3'd5, 32'h12, 32'h0,        32'h0000CAFE, 1'b0, 2, 0, 32'hCAFE55EF};
    tv[13] = '{1'b0, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 32'hCAFE55EF};
    tv[14] = '{1'b1, 3'd4, 32'h10, 32'h11,       32'h0,        1'b1, 1, 0, 32'hCAFE55EF};
    tv[15] = '{1'b0, 3'd4, 32'h11, 32'h0,        32'h00000055, 1'b0, 2, 0, 32'hCAFE55EF};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata,          32'h0);
    chk("rst_resp_err",   {31'h0, bus.resp_err},   32'h0);
    chk("rst_mem_we",     {31'h0, mem_we},         32'h0);
    chk("rst_mem_addr",   mem_addr,                32'h0);
    chk("rst_mem_wdata",  mem_wdata,               32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      model(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, m_rd, m_err, m_lat, m_wes);
      do_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, rd, err, lat, wes);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, tv[i].err});
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("vec%0d_we_cycles", i), 32'(wes), 32'(tv[i].wes));
      chk($sformatf("vec%0d_word4", i), mem[4], tv[i].word4);
    end

    // Reset while an SB sits in WR: the write must not commit and no response follows.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'h000000A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_we_in_wr", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'h0, mem_we}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    nresp = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    chk("abort_no_resp", 32'(nresp), 32'h0);
    chk("abort_word4", mem[4], ref_mem[4]);

    model(1'b1, 3'd2, 32'h1000, 32'h1, m_rd, m_err, m_lat, m_wes);
    do_req(1'b1, 3'd2, 32'h1000, 32'h1, rd, err, lat, wes);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("oob_err", {31'h0, err}, 32'h1);
    chk("oob_lat", 32'(lat), 32'd1);
    chk("oob_word0", mem[0], 32'h0);
`else
    chk("wrap_err", {31'h0, err}, 32'h0);
    chk("wrap_lat", 32'(lat), 32'd2);
    chk("wrap_word0", mem[0], 32'h00000001);
`endif

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 255) << 12);
      wd = $urandom;
      model(we, f3, a, wd, m_rd, m_err, m_lat, m_wes);
      do_req(we, f3, a, wd, rd, err, lat, wes);
      idx = int'((a >> 2) % DEPTH);
      chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
      chk($sformatf("rnd%0d_err", i), {31'h0, err}, {31'h0, m_err});
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(m_lat));
      chk($sformatf("rnd%0d_we_cycles", i), 32'(wes), 32'(m_wes));
      chk($sformatf("rnd%0d_word", i), mem[idx], ref_mem[idx]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
